// File: rtl/vedic_mul_pipe.sv
// Purpose: pipelined Vedic (Urdhva-Tiryagbhyam) multiplier, signed or unsigned per operation.
// Latency: 3 clk from input transfer to out_valid; one result per cycle when out_ready is held high.
// Backpressure: a single advance enable freezes every stage while out_valid is held and out_ready is low.
module vedic_mul_pipe #(
    parameter int WIDTH     = 8,
    parameter int SIGNED_EN = 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   product,
    output logic                 busy
);

    localparam int  HALF = WIDTH / 2;
    localparam int  PW   = 2 * WIDTH;
    localparam int  XW   = 2 * WIDTH + 1;
    localparam bit  SEN  = (SIGNED_EN != 0);

    logic             adv;

    // stage 1: raw operands plus effective sign mode
    logic             s1_vld;
    logic             s1_sm;
    logic [WIDTH-1:0] s1_a;
    logic [WIDTH-1:0] s1_b;

    // stage 2: the four cross partial products and the result sign
    logic             s2_vld;
    logic             s2_neg;
    logic [WIDTH-1:0] s2_hh;
    logic [WIDTH-1:0] s2_hl;
    logic [WIDTH-1:0] s2_lh;
    logic [WIDTH-1:0] s2_ll;

    logic             a_neg;
    logic             b_neg;
    logic [WIDTH-1:0] mag_a;
    logic [WIDTH-1:0] mag_b;
    logic [HALF-1:0]  a_hi;
    logic [HALF-1:0]  a_lo;
    logic [HALF-1:0]  b_hi;
    logic [HALF-1:0]  b_lo;
    logic [WIDTH-1:0] pp_hh;
    logic [WIDTH-1:0] pp_hl;
    logic [WIDTH-1:0] pp_lh;
    logic [WIDTH-1:0] pp_ll;

    logic [WIDTH:0]   mid_sum;
    logic [XW-1:0]    sum_x;
    logic [XW-1:0]    res_x;

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;
    assign busy     = s1_vld || s2_vld || out_valid;

    // -2^(WIDTH-1) negates onto itself, which read unsigned is the correct magnitude
    always_comb begin
        a_neg = s1_sm && s1_a[WIDTH-1];
        b_neg = s1_sm && s1_b[WIDTH-1];
        mag_a = a_neg ? -s1_a : s1_a;
        mag_b = b_neg ? -s1_b : s1_b;
        a_hi  = mag_a[WIDTH-1:HALF];
        a_lo  = mag_a[HALF-1:0];
        b_hi  = mag_b[WIDTH-1:HALF];
        b_lo  = mag_b[HALF-1:0];
        pp_hh = WIDTH'(a_hi) * WIDTH'(b_hi);
        pp_hl = WIDTH'(a_hi) * WIDTH'(b_lo);
        pp_lh = WIDTH'(a_lo) * WIDTH'(b_hi);
        pp_ll = WIDTH'(a_lo) * WIDTH'(b_lo);
    end

    // zero magnitude negates to zero, so no negative-zero can escape
    always_comb begin
        mid_sum = {1'b0, s2_hl} + {1'b0, s2_lh};
        sum_x   = (XW'(s2_hh) << WIDTH) + (XW'(mid_sum) << HALF) + XW'(s2_ll);
        res_x   = s2_neg ? (XW'(0) - sum_x) : sum_x;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_vld    <= 1'b0;
            s1_sm     <= 1'b0;
            s1_a      <= '0;
            s1_b      <= '0;
            s2_vld    <= 1'b0;
            s2_neg    <= 1'b0;
            s2_hh     <= '0;
            s2_hl     <= '0;
            s2_lh     <= '0;
            s2_ll     <= '0;
            out_valid <= 1'b0;
            product   <= '0;
        end else if (adv) begin
            s1_vld    <= in_valid;
            s2_vld    <= s1_vld;
            out_valid <= s2_vld;
            if (in_valid) begin
                s1_a  <= a;
                s1_b  <= b;
                s1_sm <= signed_mode && SEN;
            end
            if (s1_vld) begin
                s2_hh  <= pp_hh;
                s2_hl  <= pp_hl;
                s2_lh  <= pp_lh;
                s2_ll  <= pp_ll;
                s2_neg <= a_neg ^ b_neg;
            end
            if (s2_vld) begin
                product <= PW'(res_x);
            end
        end
    end

endmodule

// File: tb/tb_vedic_mul_pipe.sv
// Bench for vedic_mul_pipe (WIDTH=8): directed literal cases plus randomized traffic
// scored against an integer-arithmetic reference multiply.
module tb_vedic_mul_pipe;

    localparam int W = 8;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           in_valid = 1'b0;
    logic           out_ready = 1'b1;
    logic           signed_mode = 1'b0;
    logic [W-1:0]   a = '0;
    logic [W-1:0]   b = '0;
    logic           in_ready;
    logic           out_valid;
    logic           busy;
    logic [2*W-1:0] product;

    vedic_mul_pipe #(.WIDTH(W), .SIGNED_EN(1)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .a           (a),
        .b           (b),
        .signed_mode (signed_mode),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .product     (product),
        .busy        (busy)
    );

    initial forever #5 clk = ~clk;

    typedef struct {
        logic [15:0] exp_p;
        logic [15:0] lit;
        bit          has_lit;
        bit          lat_chk;
        int          cyc;
    } ent_t;

    ent_t        q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    int          drain = 0;
    int          or_mode = 0;
    bit          front_seen = 0;
    bit          stim_done = 0;
    bit          hang = 0;
    logic [15:0] cur_lit = '0;
    bit          cur_has = 0;
    bit          cur_lat = 0;

    // reference: plain integer multiply of the operands as the mode interprets them
    function automatic logic [15:0] ref_mul(input logic [7:0] x, input logic [7:0] y, input bit sm);
        int xi;
        int yi;
        int p;
        xi = (sm && x[7]) ? int'(x) - 256 : int'(x);
        yi = (sm && y[7]) ? int'(y) - 256 : int'(y);
        p  = xi * yi;
        return p[15:0];
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    task automatic finish_run();
        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    endtask

    // single compare process: reset state, handshake rules, scoreboard
    initial begin
        forever begin
            @(negedge clk or negedge rst_n);
            if (!rst_n) begin
                #1;
                chk("rst_out_valid", 32'(out_valid), 32'(0));
                chk("rst_busy", 32'(busy), 32'(0));
                chk("rst_product", 32'(product), 32'(0));
                chk("rst_in_ready", 32'(in_ready), 32'(1));
                q.delete();
                front_seen = 0;
            end else begin
                cyc++;
                chk("in_ready_rule", 32'(in_ready), 32'(!out_valid || out_ready));
                chk("busy_vs_inflight", 32'(busy), 32'(q.size() != 0));
                if (out_valid) begin
                    if (q.size() == 0) begin
                        chk("spurious_out_valid", 32'(out_valid), 32'(0));
                    end else begin
                        if (!front_seen) begin
                            front_seen = 1;
                            if (q[0].lat_chk)
                                chk("latency", 32'(cyc - q[0].cyc), 32'(3));
                        end
                        chk("product_vs_model", 32'(product), 32'(q[0].exp_p));
                        if (q[0].has_lit)
                            chk("product_literal", 32'(product), 32'(q[0].lit));
                        if (out_ready) begin
                            void'(q.pop_front());
                            front_seen = 0;
                        end
                    end
                end
                if (in_valid && in_ready)
                    q.push_back('{exp_p: ref_mul(a, b, signed_mode), lit: cur_lit,
                                  has_lit: cur_has, lat_chk: cur_lat, cyc: cyc});
                if (hang) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL input_accept: in_ready never rose within 100 cycles");
                    finish_run();
                end
                if (stim_done) begin
                    if (q.size() == 0) begin
                        finish_run();
                    end else if (++drain > 500) begin
                        n_cmp++;
                        n_err++;
                        $display("FAIL drain: %0d results still pending after 500 cycles", q.size());
                        finish_run();
                    end
                end
            end
        end
    end

    // out_ready driver: 0 = always ready, 1 = random, 2 = held low
    initial begin
        forever begin
            @(posedge clk);
            #2;
            case (or_mode)
                1:       out_ready = 1'($urandom_range(0, 1));
                2:       out_ready = 1'b0;
                default: out_ready = 1'b1;
            endcase
        end
    end

    task automatic send(input logic [7:0] x, input logic [7:0] y, input bit sm,
                        input logic [15:0] lit, input bit has, input bit lat);
        int t;
        bit acc;
        in_valid    = 1'b1;
        a           = x;
        b           = y;
        signed_mode = sm;
        cur_lit     = lit;
        cur_has     = has;
        cur_lat     = lat;
        t = 0;
        do begin
            @(negedge clk);
            acc = in_ready;
            @(posedge clk);
            #1;
            t++;
        end while (!acc && t < 100);
        if (!acc) hang = 1;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        cur_has  = 0;
        cur_lat  = 0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    logic [7:0] corner [5];

    initial begin
        corner[0] = 8'h00; corner[1] = 8'h01; corner[2] = 8'h7F;
        corner[3] = 8'h80; corner[4] = 8'hFF;

        #12;
        @(posedge clk);
        #2 rst_n = 1'b1;

        // first transfer right after release, exact latency
        send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1, 1);
        idle(6);

        // signed boundary cases
        send(8'h80, 8'h80, 1'b1, 16'h4000, 1, 1);
        send(8'hFF, 8'h7F, 1'b1, 16'hFF81, 1, 1);
        send(8'h00, 8'h80, 1'b1, 16'h0000, 1, 1);
        idle(5);

        // alternating mode, same operands
        send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1, 1);
        send(8'hFF, 8'hFF, 1'b1, 16'h0001, 1, 1);
        send(8'hFF, 8'hFF, 1'b0, 16'hFE01, 1, 1);
        send(8'hFF, 8'hFF, 1'b1, 16'h0001, 1, 1);
        idle(5);

        // stream under a 5-cycle output stall
        or_mode = 2;
        fork
            begin
                send(8'h03, 8'h05, 1'b0, 16'h000F, 1, 0);
                send(8'h07, 8'h09, 1'b0, 16'h003F, 1, 0);
                send(8'h0F, 8'h10, 1'b0, 16'h00F0, 1, 0);
                send(8'h12, 8'h34, 1'b0, 16'h03A8, 1, 0);
                idle(1);
            end
            begin
                repeat (5) @(posedge clk);
                or_mode = 0;
            end
        join
        idle(6);

        // asynchronous reset with two operations in flight
        send(8'h0B, 8'h0D, 1'b0, 16'h008F, 1, 0);
        send(8'h71, 8'h05, 1'b0, 16'h0235, 1, 0);
        in_valid = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #2 rst_n = 1'b1;
        send(8'h05, 8'h06, 1'b0, 16'h001E, 1, 1);
        idle(8);

        // randomized traffic with random output backpressure
        or_mode = 1;
        for (int i = 0; i < 3000; i++) begin
            logic [31:0] r;
            logic [7:0]  xa;
            logic [7:0]  xb;
            r  = $urandom;
            xa = r[7:0];
            xb = r[15:8];
            if (r[24:22] == 3'd0) xa = corner[r[27:25] % 5];
            if (r[30:28] == 3'd0) xb = corner[r[27:25] % 5];
            send(xa, xb, r[16], 16'h0, 0, 0);
            if (r[19:18] == 2'd0) idle(int'(r[21:20]));
        end
        in_valid = 1'b0;
        or_mode  = 0;
        stim_done = 1;
    end

endmodule
